uart_ctrl: RTL

Memory-mapped UART controller between the CPU32 data bus and the RS-232 transmitter/receiver pair. It buffers outgoing bytes in a TX FIFO and sequences them into the transmitter through its start/busy handshake. It captures each receiver data-ready pulse into an RX FIFO and exposes data, status and an interrupt to the CPU. It holds no baud logic; all bit timing stays in the transmitter and receiver.

---
 rtl/uart_ctrl_if.sv | 28 ++
 rtl/uart_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: CPU bus port plus transmitter/receiver handshakes for uart_ctrl.
// Latency: none, wires only.
// Backpressure: none on the bus; the transmitter paces itself with tx_busy.
interface uart_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic        bus_addr;
  logic [7:0]  bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready;
  logic [7:0]  rx_data;

  // Environment side: CPU, transmitter busy and receiver outputs.
  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata, tx_busy, rx_ready, rx_data,
    input  bus_rdata, irq, tx_start, tx_data
  );

  // Controller side.
  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata, tx_busy, rx_ready, rx_data,
    output bus_rdata, irq, tx_start, tx_data
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped UART controller with TX/RX byte FIFOs and start/busy TX sequencing.
// Latency: reads return the cycle after bus_sel; a DATA write raises tx_start two edges later.
// Backpressure: none on the bus; full FIFOs drop bytes and set sticky tx_ovf / rx_ovr.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_ctrl_if.slave bus
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, SEND} txState_t;

  logic [7:0]    txMem [FIFO_DEPTH];
  logic [7:0]    rxMem [FIFO_DEPTH];
  logic [AW-1:0] txRdPtr, txWrPtr, rxRdPtr, rxWrPtr;
  logic [AW:0]   txCount, rxCount;
  txState_t      state, stateNext;
  logic          txPop, txStartReg;
  logic [7:0]    txDataReg;
  logic [31:0]   rdataReg;
  logic          rxOvr, txOvf;

  logic          dataWr, dataRd, statusRd;
  logic          txFull, rxFull, rxAvail, txIdle;
  logic          txPush, txOvfSet, rxPop, rxPush, rxOvrSet;
  logic [31:0]   statusWord;

  assign dataWr   = bus.bus_sel &  bus.bus_we & ~bus.bus_addr;
  assign dataRd   = bus.bus_sel & ~bus.bus_we & ~bus.bus_addr;
  assign statusRd = bus.bus_sel & ~bus.bus_we &  bus.bus_addr;

  assign txFull   = (txCount == FullCount);
  assign rxFull   = (rxCount == FullCount);
  assign rxAvail  = (rxCount != '0);
  assign txIdle   = (txCount == '0) && (state == IDLE);

  // A full TX FIFO drops the write even if the FSM pops in the same cycle.
  assign txPush   = dataWr & ~txFull;
  assign txOvfSet = dataWr &  txFull;

  // RX may accept into a full FIFO when the CPU pops the head in the same cycle.
  assign rxPop    = dataRd & rxAvail;
  assign rxPush   = bus.rx_ready & (~rxFull | rxPop);
  assign rxOvrSet = bus.rx_ready & rxFull & ~rxPop;

  assign statusWord = {8'h00, 8'(txCount), 8'(rxCount), 3'b000,
                       txOvf, rxOvr, txIdle, txFull, rxAvail};

  assign bus.bus_rdata = rdataReg;
  assign bus.irq       = rxAvail;
  assign bus.tx_start  = txStartReg;
  assign bus.tx_data   = txDataReg;

  // TX sequencer next state: IDLE also waits for tx_busy low so a byte left over across reset is never overlapped.
  always_comb begin
    stateNext = state;
    txPop     = 1'b0;
    unique case (state)
      IDLE: begin
        if ((txCount != '0) && !bus.tx_busy) begin
          txPop     = 1'b1;
          stateNext = START;
        end
      end
      START:   if (bus.tx_busy)  stateNext = SEND;
      SEND:    if (!bus.tx_busy) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // TX sequencer state, one-cycle start pulse and held transmit byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      txStartReg <= 1'b0;
      txDataReg  <= '0;
    end else begin
      state      <= stateNext;
      txStartReg <= txPop;
      if (txPop) txDataReg <= txMem[txRdPtr];
    end
  end

  // FIFO storage; contents need no reset since the counts gate every read.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr] <= bus.bus_wdata;
    if (rxPush) rxMem[rxWrPtr] <= bus.rx_data;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop)  txRdPtr <= txRdPtr + 1'b1;
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: ;
      endcase
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + 1'b1;
        2'b01:   rxCount <= rxCount - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error flags clear on STATUS read, a same-cycle set wins; read data holds until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txOvf    <= 1'b0;
      rxOvr    <= 1'b0;
      rdataReg <= '0;
    end else begin
      txOvf <= txOvfSet | (txOvf & ~statusRd);
      rxOvr <= rxOvrSet | (rxOvr & ~statusRd);
      if (dataRd)        rdataReg <= rxAvail ? {24'h0, rxMem[rxRdPtr]} : 32'h0;
      else if (statusRd) rdataReg <= statusWord;
    end
  end

endmodule
